// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results to writeback and runs loads/stores as byte-serial
// transactions on an 8-bit controller port. Optional macro MEM_MISALIGN_TRAP_EN adds out_misalign.
module mem_access_stage #(
  parameter int          ADDR_W   = 32,
  parameter logic [6:0]  LOAD_OP  = 7'b0000011,
  parameter logic [6:0]  STORE_OP = 7'b0100011
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              in_forward,
  input  logic [4:0]        in_rd_addr,
  input  logic [31:0]       in_rd_val,
  input  logic [6:0]        in_ins_type,
  input  logic [2:0]        in_ins_details,
  input  logic [31:0]       in_mem_addr,
  input  logic [31:0]       in_mem_val,
  input  logic              stall_hold,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wdata,
  output logic              stall_req,
  output logic              out_forward,
  output logic [4:0]        out_rd_addr,
  output logic [31:0]       out_rd_val
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              out_misalign
`endif
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_done;
  logic [31:0]       r_data;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_wdata;
  logic              r_out_forward;
  logic [4:0]        r_out_rd_addr;
  logic [31:0]       r_out_rd_val;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_ack;
  logic [1:0]  w_last;
  logic        w_final;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_assembled;
  logic [31:0] w_load_val;

  assign w_is_load  = (in_ins_type == LOAD_OP);
  assign w_is_store = (in_ins_type == STORE_OP);
  assign w_is_mem   = (w_is_load || w_is_store) && !r_done;
  assign w_ack      = mem_ack && rdy_in;
  assign w_cnt_nxt  = r_cnt + 2'd1;
  assign w_addr_nxt = in_mem_addr + {30'd0, w_cnt_nxt};

  always_comb begin
    case (in_ins_details[1:0])
      2'd0:    w_last = 2'd0;
      2'd1:    w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_is_mem &&
                      (((in_ins_details[1:0] == 2'd1) && in_mem_addr[0]) ||
                       ((in_ins_details[1:0] == 2'd2) && (in_mem_addr[1:0] != 2'd0)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_final   = (r_state == S_ACCESS) && w_ack && (r_cnt == w_last);
  // Stall drops combinationally on the final ack so EX->MEM can advance on that edge.
  assign stall_req = (r_state == S_IDLE) ? (w_is_mem && !w_misalign) : !w_final;

  always_comb begin
    w_assembled = r_data;
    w_assembled[{r_cnt, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    case (in_ins_details)
      3'b000:  w_load_val = {{24{w_assembled[7]}}, w_assembled[7:0]};
      3'b001:  w_load_val = {{16{w_assembled[15]}}, w_assembled[15:0]};
      3'b100:  w_load_val = {24'd0, w_assembled[7:0]};
      3'b101:  w_load_val = {16'd0, w_assembled[15:0]};
      default: w_load_val = w_assembled;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_cnt         <= 2'd0;
      r_done        <= 1'b0;
      r_data        <= 32'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_a       <= '0;
      r_mem_wdata   <= 8'd0;
      r_out_forward <= 1'b0;
      r_out_rd_addr <= 5'd0;
      r_out_rd_val  <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misalign  <= 1'b0;
`endif
    end else if (rdy_in) begin
`ifdef MEM_MISALIGN_TRAP_EN
      out_misalign <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (w_misalign) begin
            out_misalign  <= 1'b1;
            r_out_forward <= 1'b0;
            r_out_rd_addr <= 5'd0;
            r_out_rd_val  <= in_mem_addr;
            r_done        <= stall_hold;
          end else
`endif
          if (w_is_mem) begin
            r_out_forward <= 1'b0;
            r_out_rd_addr <= 5'd0;
            r_out_rd_val  <= 32'd0;
            r_cnt         <= 2'd0;
            r_data        <= 32'd0;
            r_mem_req     <= 1'b1;
            r_mem_we      <= w_is_store;
            r_mem_a       <= in_mem_addr[ADDR_W-1:0];
            r_mem_wdata   <= in_mem_val[7:0];
            r_state       <= S_ACCESS;
          end else begin
            // A completed access still parked in EX->MEM must not write back twice.
            if (r_done && (w_is_load || w_is_store)) begin
              r_out_forward <= 1'b0;
              r_out_rd_addr <= 5'd0;
              r_out_rd_val  <= 32'd0;
            end else begin
              r_out_forward <= in_forward;
              r_out_rd_addr <= in_rd_addr;
              r_out_rd_val  <= in_rd_val;
            end
            if (!stall_hold) begin
              r_done <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          r_out_forward <= 1'b0;
          r_out_rd_addr <= 5'd0;
          r_out_rd_val  <= 32'd0;
          if (w_ack) begin
            if (r_cnt == w_last) begin
              r_state       <= S_IDLE;
              r_mem_req     <= 1'b0;
              r_mem_we      <= 1'b0;
              r_done        <= stall_hold;
              r_out_forward <= w_is_store ? 1'b0 : in_forward;
              r_out_rd_addr <= in_rd_addr;
              r_out_rd_val  <= w_is_store ? 32'd0 : w_load_val;
            end else begin
              r_data[{r_cnt, 3'b000} +: 8] <= mem_rdata;
              r_cnt       <= w_cnt_nxt;
              r_mem_a     <= w_addr_nxt[ADDR_W-1:0];
              r_mem_wdata <= in_mem_val[{w_cnt_nxt, 3'b000} +: 8];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_a       = r_mem_a;
  assign mem_wdata   = r_mem_wdata;
  assign out_forward = r_out_forward;
  assign out_rd_addr = r_out_rd_addr;
  assign out_rd_val  = r_out_rd_val;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: the bench plays the EX->MEM register and the byte-wide
// memory controller, predicting results from a byte-addressed memory model.
module tb_mem_access_stage;
  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, in_forward, stall_hold, mem_ack;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_val, in_mem_addr, in_mem_val;
  logic [6:0]  in_ins_type;
  logic [2:0]  in_ins_details;
  logic [7:0]  mem_rdata, mem_wdata;
  logic        mem_req, mem_we, stall_req, out_forward;
  logic [31:0] mem_a, out_rd_val;
  logic [4:0]  out_rd_addr;

  int n_checks = 0;
  int n_errors = 0;
  byte unsigned mem_model [bit [31:0]];

  mem_access_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .in_forward(in_forward), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val),
    .in_ins_type(in_ins_type), .in_ins_details(in_ins_details),
    .in_mem_addr(in_mem_addr), .in_mem_val(in_mem_val), .stall_hold(stall_hold),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .stall_req(stall_req),
    .out_forward(out_forward), .out_rd_addr(out_rd_addr), .out_rd_val(out_rd_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input bit [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    in_ins_type = 7'b0010011; in_ins_details = 3'd0; in_forward = 1'b0;
    in_rd_addr = 5'd0; in_rd_val = 32'd0; in_mem_addr = 32'd0; in_mem_val = 32'd0;
    stall_hold = 1'b0; mem_ack = 1'b0; mem_rdata = 8'd0; rdy_in = 1'b1;
  endtask

  task automatic do_alu(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val,
                        input logic fwd);
    in_ins_type = op; in_rd_addr = rd; in_rd_val = val; in_forward = fwd;
    in_ins_details = 3'($urandom); in_mem_addr = $urandom; in_mem_val = $urandom;
    stall_hold = 1'b0; mem_ack = 1'b0;
    #1;
    chk("alu_stall", stall_req, 1'b0);
    chk("alu_req", mem_req, 1'b0);
    tick();
    chk("alu_fwd", out_forward, fwd);
    chk("alu_rd", out_rd_addr, rd);
    chk("alu_val", out_rd_val, val);
    $display("txn alu op=%02h rd=%0d val=%08h fwd=%0d", op, rd, val, fwd);
  endtask

  // One load/store seen from the EX->MEM side; abort_after>0 asserts reset after that many acks.
  task automatic do_mem(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] val, input logic [4:0] rd, input logic fwd,
                        input int dly_lo, input int dly_hi, input bit hold_end,
                        input int abort_after);
    int n;
    int dly;
    longint acc;
    logic [31:0] ba;
    logic [31:0] exp_val;
    logic [7:0] wb;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    acc = 0;
    in_ins_type = is_store ? STORE_OP : LOAD_OP; in_ins_details = f3;
    in_mem_addr = addr; in_mem_val = val; in_rd_addr = rd; in_forward = fwd;
    in_rd_val = $urandom; stall_hold = 1'b0; mem_ack = 1'b0; rdy_in = 1'b1;
    #1;
    chk("c0_stall", stall_req, 1'b1);
    chk("c0_req", mem_req, 1'b0);
    tick();
    for (int k = 0; k < n; k++) begin
      ba = addr + 32'(k);
      wb = 8'((val >> (8 * k)) & 32'hFF);
      dly = $urandom_range(dly_hi, dly_lo);
      for (int d = 0; d < dly; d++) begin
        rdy_in = 1'($urandom_range(1, 0));
        mem_ack = 1'b0;
        #1;
        chk("wait_req", mem_req, 1'b1);
        chk("wait_addr", mem_a, ba);
        chk("wait_stall", stall_req, 1'b1);
        chk("wait_bubble", out_forward, 1'b0);
        if (is_store) chk("wait_wdata", mem_wdata, wb);
        tick();
      end
      rdy_in = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = mem_rd(ba);
      if (k == n - 1) stall_hold = hold_end;
      #1;
      chk("ack_req", mem_req, 1'b1);
      chk("ack_addr", mem_a, ba);
      chk("ack_we", mem_we, is_store);
      chk("ack_stall", stall_req, (k != n - 1));
      if (is_store) begin
        chk("ack_wdata", mem_wdata, wb);
        mem_model[ba] = wb;
      end else begin
        acc += longint'(mem_rd(ba)) << (8 * k);
      end
      tick();
      mem_ack = 1'b0;
      if (abort_after == k + 1) begin
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        idle_inputs();
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_fwd", out_forward, 1'b0);
        chk("rst_rd", out_rd_addr, 5'd0);
        chk("rst_val", out_rd_val, 32'd0);
        $display("txn %s f3=%0d addr=%08h aborted by reset after %0d bytes",
                 is_store ? "store" : "load", f3, addr, k + 1);
        return;
      end
    end
    if (!is_store && n < 4 && f3[2] == 1'b0 && acc >= (longint'(1) << (8 * n - 1)))
      acc -= longint'(1) << (8 * n);
    exp_val = is_store ? 32'd0 : acc[31:0];
    chk("res_fwd", out_forward, is_store ? 1'b0 : fwd);
    chk("res_rd", out_rd_addr, rd);
    chk("res_val", out_rd_val, exp_val);
    chk("res_req", mem_req, 1'b0);
    if (hold_end) begin
      stall_hold = 1'b1;
      #1;
      chk("hold_stall", stall_req, 1'b0);
      tick();
      chk("hold_req", mem_req, 1'b0);
      chk("hold_bubble", out_forward, 1'b0);
      chk("hold_bubble_rd", out_rd_addr, 5'd0);
      stall_hold = 1'b0;
      #1;
      chk("rel_stall", stall_req, 1'b0);
      tick();
      chk("rel_req", mem_req, 1'b0);
      chk("rel_bubble", out_forward, 1'b0);
    end
    $display("txn %s f3=%0d addr=%08h rd=%0d result=%08h", is_store ? "store" : "load",
             f3, addr, rd, exp_val);
  endtask

  initial begin
    logic [6:0] alu_ops [4];
    logic [2:0] ld_f3 [5];
    logic [31:0] pool [6];
    int sel;
    alu_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111};
    ld_f3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    pool    = '{32'h0000_0100, 32'h0000_0203, 32'h0000_0040, 32'h0000_0801,
                32'hFFFF_FFFE, 32'h0000_0010};
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    chk("reset_req", mem_req, 1'b0);
    chk("reset_we", mem_we, 1'b0);
    chk("reset_a", mem_a, 32'd0);
    chk("reset_wdata", mem_wdata, 8'd0);
    chk("reset_fwd", out_forward, 1'b0);
    chk("reset_rd", out_rd_addr, 5'd0);
    chk("reset_val", out_rd_val, 32'd0);
    rst_in = 1'b0;

    do_alu(7'b0110011, 5'd5, 32'hDEADBEEF, 1'b1);

    mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
    mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
    do_mem(1'b0, 3'd2, 32'h100, 32'd0, 5'd1, 1'b1, 0, 0, 1'b0, -1);
    mem_model[32'h203] = 8'h80;
    do_mem(1'b0, 3'd0, 32'h203, 32'd0, 5'd2, 1'b1, 0, 0, 1'b0, -1);
    do_mem(1'b0, 3'd4, 32'h203, 32'd0, 5'd3, 1'b1, 0, 0, 1'b0, -1);
    mem_model[32'h10] = 8'hFE; mem_model[32'h11] = 8'hFF;
    do_mem(1'b0, 3'd5, 32'h10, 32'd0, 5'd4, 1'b1, 0, 0, 1'b0, -1);
    do_mem(1'b0, 3'd1, 32'h10, 32'd0, 5'd4, 1'b1, 0, 0, 1'b0, -1);
    do_mem(1'b1, 3'd1, 32'h40, 32'hAABBCCDD, 5'd7, 1'b1, 3, 3, 1'b0, -1);
    do_mem(1'b0, 3'd5, 32'h40, 32'd0, 5'd8, 1'b1, 0, 1, 1'b0, -1);
    do_mem(1'b0, 3'd2, 32'h100, 32'd0, 5'd9, 1'b1, 0, 0, 1'b1, -1);
    do_mem(1'b0, 3'd2, 32'h200, 32'd0, 5'd10, 1'b1, 0, 0, 1'b0, -1);
    do_mem(1'b1, 3'd2, 32'h300, 32'h11223344, 5'd11, 1'b1, 0, 0, 1'b0, 2);
    do_mem(1'b0, 3'd2, 32'h500, 32'd0, 5'd12, 1'b1, 0, 0, 1'b0, -1);
    do_mem(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 5'd13, 1'b1, 0, 2, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(2, 0);
      if (sel == 0) begin
        do_alu(alu_ops[$urandom_range(3, 0)], 5'($urandom), $urandom, 1'($urandom));
      end else if (sel == 1) begin
        do_mem(1'b0, ld_f3[$urandom_range(4, 0)], pool[$urandom_range(5, 0)], 32'd0,
               5'($urandom), 1'($urandom), 0, 2, 1'($urandom_range(3, 0) == 0), -1);
      end else begin
        do_mem(1'b1, 3'($urandom_range(2, 0)), pool[$urandom_range(5, 0)], $urandom,
               5'($urandom), 1'b1, 0, 2, 1'($urandom_range(3, 0) == 0), -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
